alu_share_ctrl: RTL and testbench

- Sequencer and arbiter that time-shares the single 64-bit combinational ALU between two requesters, e.g. the execute stage (port 0) and the address/branch-compare unit (port 1).
- Latches one request's operands and control, drives the ALU, waits a programmable settle time for the gate-level ripple chain, then captures the result and flags.
- Returns the captured result to the granted requester through a valid/ready response handshake.

---
 rtl/alu_share_ctrl.sv | 117 +++++++++++
 tb/tb_alu_share_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter and sequencer time-sharing one 64-bit ALU between two ports
module alu_share_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a0,
  input  logic [63:0] req_b0,
  input  logic [63:0] req_a1,
  input  logic [63:0] req_b1,
  input  logic [2:0]  req_cntrl0,
  input  logic [2:0]  req_cntrl1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_cntrl,
  input  logic [63:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        port_q, port_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]  alu_cntrl_q, alu_cntrl_d;
  logic [63:0] rsp_result_q, rsp_result_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        win;
  // pick the winning port and offer ready only to it, only while idle
  always_comb begin
    win = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    req_ready = (state_q == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
  // sequence grant -> settle countdown -> response hold
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    port_d = port_q;
    cnt_d = cnt_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_cntrl_d = alu_cntrl_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (|req_ready) begin
        alu_a_d = win ? req_a1 : req_a0;
        alu_b_d = win ? req_b1 : req_b0;
        alu_cntrl_d = win ? req_cntrl1 : req_cntrl0;
        port_d = win;
        ptr_d = (req_valid == 2'b11) ? ~ptr_q : ptr_q;
        cnt_d = 4'(SETTLE_CYCLES - 1);
        state_d = EXEC;
      end
      EXEC: if (cnt_q == 4'd0) begin
        rsp_result_d = alu_result;
        rsp_flags_d = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
        rsp_valid_d = port_q ? 2'b10 : 2'b01;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready[port_q]) begin
        rsp_valid_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      port_q <= 1'b0;
      cnt_q <= 4'd0;
      alu_a_q <= 64'd0;
      alu_b_q <= 64'd0;
      alu_cntrl_q <= 3'd0;
      rsp_result_q <= 64'd0;
      rsp_flags_q <= 4'd0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      port_q <= port_d;
      cnt_q <= cnt_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_cntrl_q <= alu_cntrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_cntrl = alu_cntrl_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_valid = rsp_valid_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, latency, backpressure and reset abort
module tb_alu_share_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_cntrl0, req_cntrl1, alu_cntrl;
  logic [63:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]  rsp_flags;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out, busy;
  logic [64:0] s;
  int passed = 0;
  int total = 0;
  int n;
  logic seen;

  alu_share_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_cntrl0(req_cntrl0), .req_cntrl1(req_cntrl1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in ALU: 010 add, 011 subtract (carry = no borrow), anything else yields zero
  always_comb begin
    s = 65'd0;
    if (alu_cntrl == 3'b010) s = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_cntrl == 3'b011) s = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
    alu_result = s[63:0];
    alu_negative = s[63];
    alu_zero = s[63:0] == 64'd0;
    alu_carry_out = s[64];
    alu_overflow = (alu_cntrl == 3'b010) ? (alu_a[63] == alu_b[63]) && (s[63] != alu_a[63]) :
                   (alu_cntrl == 3'b011) ? (alu_a[63] != alu_b[63]) && (s[63] != alu_a[63]) : 1'b0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_cntrl0 = '0; req_cntrl1 = '0;
    tick(); tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_flags", 64'(rsp_flags), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_cntrl", 64'(alu_cntrl), 64'd0);
    rst_n = 1'b1;
    tick();
    // single subtract on port 0: 5-3
    req_a0 = 64'd5; req_b0 = 64'd3; req_cntrl0 = 3'b011; req_valid = 2'b01; rsp_ready = 2'b11;
    #1 chk("t1_req_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_alu_a", alu_a, 64'd5);
    chk("t1_alu_b", alu_b, 64'd3);
    chk("t1_alu_cntrl", 64'(alu_cntrl), 64'd3);
    chk("t1_valid_c1", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid_c2", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid_c3", 64'(rsp_valid), 64'd1);
    chk("t1_result", rsp_result, 64'd2);
    chk("t1_flags", 64'(rsp_flags), 64'h1);
    tick();
    chk("t1_valid_drop", 64'(rsp_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_alu_a_kept", alu_a, 64'd5);
    // port 1 signed-overflow add
    req_a1 = 64'h7FFF_FFFF_FFFF_FFFF; req_b1 = 64'd1; req_cntrl1 = 3'b010; req_valid = 2'b10;
    #1 chk("t2_req_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    chk("t2_latency", 64'(n), 64'd2);
    chk("t2_valid", 64'(rsp_valid), 64'd2);
    chk("t2_result", rsp_result, 64'h8000_0000_0000_0000);
    chk("t2_flags", 64'(rsp_flags), 64'hA);
    tick();
    // both ports contending: grants alternate 0,1,0,1
    req_a0 = 64'd9; req_b0 = 64'd9; req_cntrl0 = 3'b011;
    req_a1 = 64'hDEAD; req_b1 = 64'hDEAD; req_cntrl1 = 3'b011; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_grant", 64'(req_ready), (i % 2 == 1) ? 64'd2 : 64'd1);
      tick();
      wait_rsp(n);
      chk("t3_valid", 64'(rsp_valid), (i % 2 == 1) ? 64'd2 : 64'd1);
      chk("t3_result", rsp_result, 64'd0);
      chk("t3_flags", 64'(rsp_flags), 64'h5);
      tick();
    end
    // backpressure on port 0 with stray port 1 ready pulses
    req_a0 = 64'd100; req_b0 = 64'd1; rsp_ready = 2'b00;
    #1 chk("t4_grant0", 64'(req_ready), 64'd1);
    tick();
    wait_rsp(n);
    chk("t4_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
      tick();
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_result", rsp_result, 64'd99);
      chk("t4_hold_flags", 64'(rsp_flags), 64'h1);
      chk("t4_hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 2'b01;
    tick();
    chk("t4_valid_drop", 64'(rsp_valid), 64'd0);
    chk("t4_grant1_after", 64'(req_ready), 64'd2);
    rsp_ready = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    chk("t4_p1_valid", 64'(rsp_valid), 64'd2);
    tick();
    // reset in the middle of EXEC
    req_a0 = 64'd7; req_b0 = 64'd2; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    #1 chk("t5_valid", 64'(rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_alu_a", alu_a, 64'd0);
    chk("t5_result", rsp_result, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | (|rsp_valid);
    end
    chk("t5_no_rsp", 64'(seen), 64'd0);
    req_a1 = 64'd10; req_b1 = 64'd4; req_cntrl1 = 3'b011; req_valid = 2'b10;
    #1 chk("t5_p1_grant", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    wait_rsp(n);
    chk("t5_p1_valid", 64'(rsp_valid), 64'd2);
    chk("t5_p1_result", rsp_result, 64'd6);
    chk("t5_p1_flags", 64'(rsp_flags), 64'h1);
    tick();
    // pointer back at port 0 after reset; operand change after accept
    req_a0 = 64'd20; req_b0 = 64'd5; req_cntrl0 = 3'b011; req_valid = 2'b11;
    #1 chk("t6_ptr_rst", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00; req_a0 = 64'd1000;
    #1 chk("t6_alu_a_held", alu_a, 64'd20);
    wait_rsp(n);
    chk("t6_valid", 64'(rsp_valid), 64'd1);
    chk("t6_result", rsp_result, 64'd15);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
